ddr3_cmd_arbiter: RTL and testbench
===================================

Name: ddr3_cmd_arbiter

Overview:
- Shares the single Gowin DDR3 controller app interface between three requesters:
  - port 0: display prefetch reads (latency-critical, highest priority).
  - port 1: framebuffer pixel writes.
  - port 2: auxiliary read/write master (blitter/CPU).
- Issues one 128-bit (8x16-bit, 4-pixel) command per accepted slot.
- Tracks outstanding reads in a tag FIFO and routes returning read data to the port that issued the read.
- Sits in the clk_x1 domain between the framebuffer logic and DDR3_Memory_Interface_Top.

Parameters:
- ADDR_W, 28, app address width.
- DATA_W, 128, app data width.
- RD_TAGS, 16, maximum outstanding reads; power of two.
- STARVE_LIMIT, 64, cycles a pending port-1/port-2 request may lose to port 0 before it is forced through.

Ports:
- clk  in  1  clk_x1 domain clock.
- rst_n  in  1  synchronous active-low reset.
- init_calib_complete  in  1  DDR3 calibration done; no issue while low.
- p0_rd_req  in  1  port 0 read request (level).
- p0_rd_addr  in  ADDR_W  port 0 address.
- p0_gnt  out  1  port 0 grant pulse.
- p0_rd_valid  out  1  port 0 read data valid.
- p0_rd_data  out  DATA_W  port 0 read data.
- p1_wr_req  in  1  port 1 write request (level).
- p1_wr_addr  in  ADDR_W  port 1 address.
- p1_wr_data  in  DATA_W  port 1 write data.
- p1_gnt  out  1  port 1 grant pulse.
- p2_req  in  1  port 2 request (level).
- p2_we  in  1  port 2 direction: 1 write, 0 read.
- p2_addr  in  ADDR_W  port 2 address.
- p2_wdata  in  DATA_W  port 2 write data.
- p2_gnt  out  1  port 2 grant pulse.
- p2_rd_valid  out  1  port 2 read data valid.
- p2_rd_data  out  DATA_W  port 2 read data.
- app_rdy  in  1  controller command ready.
- app_wdf_rdy  in  1  controller write-data ready.
- app_en  out  1  command strobe.
- app_cmd  out  3  command: 000 write, 001 read.
- app_addr  out  ADDR_W  command address.
- app_wdf_wren  out  1  write-data strobe.
- app_wdf_data  out  DATA_W  write data.
- app_rd_data_valid  in  1  controller read data valid.
- app_rd_data  in  DATA_W  controller read data.
- rd_orphan_err  out  1  sticky flag: read data arrived with no outstanding tag.

Behaviour:
- Reset: while rst_n is low at a clk edge, every output register clears to 0, the tag FIFO empties, round-robin points to port 1, and starvation counters clear. Outstanding reads are abandoned.
- Issue condition in cycle N requires all of: init_calib_complete, app_rdy, app_wdf_rdy, at least one eligible request. Reads additionally need tag count < RD_TAGS; a read-blocked port is ineligible while writes may still go.
- Winner selection, evaluated combinationally in cycle N:
  - A starved port (counter == STARVE_LIMIT) goes first; if both ports 1 and 2 are starved, the round-robin pick applies.
  - Otherwise port 0 wins.
  - Otherwise ports 1 and 2 are chosen by round-robin, favouring the port not granted last.
- Issue timing: registered in cycle N+1.
  - app_en=1; app_cmd, app_addr and the winner's gnt are driven.
  - For writes, app_wdf_wren=1 with app_wdf_data in the same cycle (app_wdf_end is tied high outside this block).
- Requesters hold req, address and data stable until they sample gnt. A port whose gnt is high is masked from arbitration in that cycle, so one request never issues twice.
- Starvation counters (ports 1 and 2):
  - increment, saturating at STARVE_LIMIT, each cycle the port requests but is not the winner while the issue condition holds;
  - clear on that port's grant or when its req is low.
- Read tagging: each issued read pushes its port id (0 or 2) into the tag FIFO in the issue cycle.
- Read return: app_rd_data_valid pops the FIFO head. One cycle later the matching pX_rd_valid pulses with pX_rd_data = captured app_rd_data. Return order equals issue order.
- Simultaneous push and pop: count unchanged, both take effect.
- Valid beat with an empty FIFO: the beat is dropped and rd_orphan_err is set; it stays set until reset.
- While init_calib_complete is low: no grants; requests wait.
- Address and data pass through unmodified; no address arithmetic is done here.

Optional Feature:
- Macro: DDR3_ARB_STATS_EN.
- Defined:
  - adds output ports stat_gnt0, stat_gnt1, stat_gnt2 (32-bit, count grants, wrap on overflow);
  - adds stat_maxwait (16-bit, largest port-0 request-to-grant latency seen);
  - all statistics clear on reset.
- Undefined: those ports are absent and no counter logic is generated.

Decomposition:
- Package ddr3_arb_pkg holds:
  - command encodings CMD_WRITE=3'b000, CMD_READ=3'b001;
  - port-id typedef (2 bits) with PORT_DISP=0, PORT_FB=1, PORT_AUX=2;
  - default widths.
- Sub-module ddr3_tag_fifo: synchronous FIFO of RD_TAGS 2-bit entries with count, full, empty and simultaneous push/pop. All arbitration stays in the top.

Test Plan:
- p1 and p2 requesting continuously, p0 idle, app_rdy=1 -> grants alternate p1,p2,p1,p2; app_cmd 000 for p1, matching p2_we.
- p0 requests every cycle, p1 requests once, STARVE_LIMIT=64 -> p1 granted in the 65th issue slot; p0 continues afterward.
- Issue 16 p0 reads with no data returned -> 17th read withheld (no p0_gnt) while a pending p1 write is still granted; one returned beat frees a tag and the next read issues.
- Interleaved p0 and p2 reads, returns with data 0x…01, 0x…02, 0x…03 -> each beat appears on the issuing port's valid/data exactly one cycle after app_rd_data_valid, in issue order.
- app_rd_data_valid with an empty FIFO -> no port valid, rd_orphan_err=1 until rst_n pulses low.
- rst_n low for one cycle with 5 reads outstanding -> all outputs 0 the next cycle, tag count 0; init_calib_complete=0 afterward -> no grants despite requests.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared encodings and default widths for the DDR3 command arbiter slice.
package ddr3_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 28;
    localparam int unsigned DATA_W_DEF       = 128;
    localparam int unsigned RD_TAGS_DEF      = 16;
    localparam int unsigned STARVE_LIMIT_DEF = 64;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        PORT_DISP = 2'd0,
        PORT_FB   = 2'd1,
        PORT_AUX  = 2'd2
    } port_id_t;

endpackage

// File: rtl/ddr3_tag_fifo.sv
// Read-tag FIFO: remembers which port issued each outstanding read, in issue order.
module ddr3_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned DEPTH = RD_TAGS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  port_id_t                 push_id,
    input  logic                     pop,
    output port_id_t                 head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    port_id_t       mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Three-port arbiter in front of the DDR3 app interface with read-return routing.
// Optional grant/latency statistics ports are enabled by DDR3_ARB_STATS_EN.
module ddr3_cmd_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned RD_TAGS      = RD_TAGS_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              p0_rd_req,
    input  logic [ADDR_W-1:0] p0_rd_addr,
    output logic              p0_gnt,
    output logic              p0_rd_valid,
    output logic [DATA_W-1:0] p0_rd_data,
    input  logic              p1_wr_req,
    input  logic [ADDR_W-1:0] p1_wr_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    output logic              p1_gnt,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_wdata,
    output logic              p2_gnt,
    output logic              p2_rd_valid,
    output logic [DATA_W-1:0] p2_rd_data,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic [DATA_W-1:0] app_wdf_data,
    input  logic              app_rd_data_valid,
    input  logic [DATA_W-1:0] app_rd_data,
    output logic              rd_orphan_err
`ifdef DDR3_ARB_STATS_EN
    ,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [31:0]       stat_gnt2,
    output logic [15:0]       stat_maxwait
`endif
);

    localparam int unsigned CW = $clog2(RD_TAGS) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] TAGS_C   = CW'(RD_TAGS);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    logic [CW-1:0] tag_count;
    logic          tag_full;
    logic          tag_empty;
    port_id_t      tag_head;
    port_id_t      tag_in;
    logic          tag_push;
    logic          tag_pop;

    port_id_t      rr_next;
    logic [SW-1:0] starve1;
    logic [SW-1:0] starve2;

    logic rd_ok, issue_ok, issue_go;
    logic elig0, elig1, elig2;
    logic starved1, starved2, rr_pick1;
    logic win0, win1, win2;

    // A port whose grant is showing this cycle is masked so one request never issues twice.
    assign rd_ok    = (tag_count < TAGS_C);
    assign issue_ok = init_calib_complete && app_rdy && app_wdf_rdy;
    assign elig0    = p0_rd_req && !p0_gnt && rd_ok;
    assign elig1    = p1_wr_req && !p1_gnt;
    assign elig2    = p2_req && !p2_gnt && (p2_we || rd_ok);
    assign issue_go = issue_ok && (elig0 || elig1 || elig2);
    assign starved1 = elig1 && (starve1 == STARVE_C);
    assign starved2 = elig2 && (starve2 == STARVE_C);
    assign rr_pick1 = elig1 && (!elig2 || (rr_next == PORT_FB));

    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        win2 = 1'b0;
        if (issue_ok) begin
            if (starved1 && starved2) begin
                win1 = (rr_next == PORT_FB);
                win2 = (rr_next != PORT_FB);
            end else if (starved1) begin
                win1 = 1'b1;
            end else if (starved2) begin
                win2 = 1'b1;
            end else if (elig0) begin
                win0 = 1'b1;
            end else if (elig1 || elig2) begin
                win1 = rr_pick1;
                win2 = !rr_pick1;
            end
        end
    end

    // Tags are pushed on the same edge that registers the command, so the credit check never overbooks.
    assign tag_push = win0 || (win2 && !p2_we);
    assign tag_in   = win0 ? PORT_DISP : PORT_AUX;
    assign tag_pop  = app_rd_data_valid && !tag_empty;

    ddr3_tag_fifo #(
        .DEPTH (RD_TAGS)
    ) u_tags (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tag_push),
        .push_id (tag_in),
        .pop     (tag_pop),
        .head    (tag_head),
        .count   (tag_count),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (tag_full == (tag_count == TAGS_C));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            app_en        <= 1'b0;
            app_cmd       <= '0;
            app_addr      <= '0;
            app_wdf_wren  <= 1'b0;
            app_wdf_data  <= '0;
            p0_gnt        <= 1'b0;
            p1_gnt        <= 1'b0;
            p2_gnt        <= 1'b0;
            p0_rd_valid   <= 1'b0;
            p0_rd_data    <= '0;
            p2_rd_valid   <= 1'b0;
            p2_rd_data    <= '0;
            rd_orphan_err <= 1'b0;
            rr_next       <= PORT_FB;
            starve1       <= '0;
            starve2       <= '0;
        end else begin
            app_en       <= win0 || win1 || win2;
            app_wdf_wren <= win1 || (win2 && p2_we);
            p0_gnt       <= win0;
            p1_gnt       <= win1;
            p2_gnt       <= win2;

            if (win0) begin
                app_cmd  <= CMD_READ;
                app_addr <= p0_rd_addr;
            end else if (win1) begin
                app_cmd      <= CMD_WRITE;
                app_addr     <= p1_wr_addr;
                app_wdf_data <= p1_wr_data;
            end else if (win2) begin
                app_cmd      <= p2_we ? CMD_WRITE : CMD_READ;
                app_addr     <= p2_addr;
                app_wdf_data <= p2_wdata;
            end

            if (win1)      rr_next <= PORT_AUX;
            else if (win2) rr_next <= PORT_FB;

            if (!p1_wr_req || win1 || p1_gnt)           starve1 <= '0;
            else if (issue_go && starve1 != STARVE_C)   starve1 <= starve1 + 1'b1;
            if (!p2_req || win2 || p2_gnt)              starve2 <= '0;
            else if (issue_go && starve2 != STARVE_C)   starve2 <= starve2 + 1'b1;

            p0_rd_valid <= tag_pop && (tag_head == PORT_DISP);
            p2_rd_valid <= tag_pop && (tag_head == PORT_AUX);
            if (tag_pop && tag_head == PORT_DISP) p0_rd_data <= app_rd_data;
            if (tag_pop && tag_head == PORT_AUX)  p2_rd_data <= app_rd_data;
            if (app_rd_data_valid && tag_empty)   rd_orphan_err <= 1'b1;
        end
    end

`ifdef DDR3_ARB_STATS_EN
    logic [15:0] p0_wait;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_gnt0    <= '0;
            stat_gnt1    <= '0;
            stat_gnt2    <= '0;
            stat_maxwait <= '0;
            p0_wait      <= '0;
        end else begin
            if (p0_gnt) stat_gnt0 <= stat_gnt0 + 1'b1;
            if (p1_gnt) stat_gnt1 <= stat_gnt1 + 1'b1;
            if (p2_gnt) stat_gnt2 <= stat_gnt2 + 1'b1;
            if (p0_gnt) begin
                if (p0_wait > stat_maxwait) stat_maxwait <= p0_wait;
                p0_wait <= '0;
            end else if (p0_rd_req && p0_wait != '1) begin
                p0_wait <= p0_wait + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed self-checking bench for ddr3_cmd_arbiter: vector table plus multi-cycle sequences.
module tb_ddr3_cmd_arbiter;
    import ddr3_arb_pkg::*;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam logic [AW-1:0] A0 = 28'h0000100;
    localparam logic [AW-1:0] A1 = 28'h0000200;
    localparam logic [AW-1:0] A2 = 28'h0000300;
    localparam logic [DW-1:0] P1D = {32'h1111_AAAA, 96'h0};
    localparam logic [DW-1:0] P2D = {32'h2222_BBBB, 96'h5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, init_calib_complete;
    logic          p0_rd_req, p0_gnt, p0_rd_valid;
    logic [AW-1:0] p0_rd_addr;
    logic [DW-1:0] p0_rd_data;
    logic          p1_wr_req, p1_gnt;
    logic [AW-1:0] p1_wr_addr;
    logic [DW-1:0] p1_wr_data;
    logic          p2_req, p2_we, p2_gnt, p2_rd_valid;
    logic [AW-1:0] p2_addr;
    logic [DW-1:0] p2_wdata, p2_rd_data;
    logic          app_rdy, app_wdf_rdy, app_en, app_wdf_wren;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] app_wdf_data;
    logic          app_rd_data_valid;
    logic [DW-1:0] app_rd_data;
    logic          rd_orphan_err;
`ifdef DDR3_ARB_STATS_EN
    logic [31:0]   stat_gnt0, stat_gnt1, stat_gnt2;
    logic [15:0]   stat_maxwait;
`endif

    ddr3_cmd_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .RD_TAGS      (16),
        .STARVE_LIMIT (64)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_calib_complete (init_calib_complete),
        .p0_rd_req           (p0_rd_req),
        .p0_rd_addr          (p0_rd_addr),
        .p0_gnt              (p0_gnt),
        .p0_rd_valid         (p0_rd_valid),
        .p0_rd_data          (p0_rd_data),
        .p1_wr_req           (p1_wr_req),
        .p1_wr_addr          (p1_wr_addr),
        .p1_wr_data          (p1_wr_data),
        .p1_gnt              (p1_gnt),
        .p2_req              (p2_req),
        .p2_we               (p2_we),
        .p2_addr             (p2_addr),
        .p2_wdata            (p2_wdata),
        .p2_gnt              (p2_gnt),
        .p2_rd_valid         (p2_rd_valid),
        .p2_rd_data          (p2_rd_data),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_data        (app_wdf_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data         (app_rd_data),
        .rd_orphan_err       (rd_orphan_err)
`ifdef DDR3_ARB_STATS_EN
        ,
        .stat_gnt0           (stat_gnt0),
        .stat_gnt1           (stat_gnt1),
        .stat_gnt2           (stat_gnt2),
        .stat_maxwait        (stat_maxwait)
`endif
    );

    typedef struct {
        logic          p0, p1, p2, we, rdy, wrdy, init;
        logic [2:0]    gnt;    // {p0, p1, p2}
        logic          en;
        logic [2:0]    cmd;
        logic          wren;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t vecs [14];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_rd_req = 1'b0; p1_wr_req = 1'b0; p2_req = 1'b0; p2_we = 1'b0;
        app_rd_data_valid = 1'b0; app_rd_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {p0_gnt, p1_gnt, p2_gnt, p0_rd_valid, p2_rd_valid,
                              app_en, app_cmd, app_wdf_wren, rd_orphan_err}, '0);
        check({tag, "_addr"}, app_addr, '0);
        check({tag, "_wdata"}, app_wdf_data, '0);
        check({tag, "_p0data"}, p0_rd_data, '0);
        check({tag, "_p2data"}, p2_rd_data, '0);
        check({tag, "_tags"}, dut.tag_count, '0);
    endtask

    task automatic grant_one(input int port, input logic we, input string name);
        logic seen;
        seen = 1'b0;
        case (port)
            0:       p0_rd_req = 1'b1;
            1:       p1_wr_req = 1'b1;
            default: begin p2_req = 1'b1; p2_we = we; end
        endcase
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = (port == 0) ? p0_gnt : (port == 1) ? p1_gnt : p2_gnt;
        end
        p0_rd_req = 1'b0; p1_wr_req = 1'b0; p2_req = 1'b0;
        check(name, seen, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          any;
        int            n;
        int            slot;
        int            outst;
        logic [DW-1:0] d1, d2, d3;

        d1 = {32'hDEAD_BEEF, 88'h0, 8'h01};
        d2 = {32'hDEAD_BEEF, 88'h0, 8'h02};
        d3 = {32'hDEAD_BEEF, 88'h0, 8'h03};

        //               p0    p1    p2    we    rdy   wrdy  init  gnt     en    cmd        wren  addr
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, CMD_WRITE, 1'b1, A1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, CMD_WRITE, 1'b1, A2};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, CMD_WRITE, 1'b1, A1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, CMD_READ,  1'b0, A2};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, CMD_WRITE, 1'b1, A1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1, CMD_READ,  1'b0, A0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, CMD_WRITE, 1'b1, A2};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 1'b1, CMD_READ,  1'b0, A0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, CMD_WRITE, 1'b0, '0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, CMD_WRITE, 1'b0, '0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, CMD_WRITE, 1'b0, '0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, CMD_WRITE, 1'b0, '0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, CMD_WRITE, 1'b1, A1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, CMD_WRITE, 1'b0, '0};

        idle_inputs();
        p0_rd_addr = A0; p1_wr_addr = A1; p1_wr_data = P1D; p2_addr = A2; p2_wdata = P2D;
        init_calib_complete = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_all_zero("reset");

        // Vector table: inputs for one cycle, registered outputs checked after the next edge.
        for (int i = 0; i < 14; i++) begin
            p0_rd_req = vecs[i].p0; p1_wr_req = vecs[i].p1; p2_req = vecs[i].p2; p2_we = vecs[i].we;
            app_rdy = vecs[i].rdy; app_wdf_rdy = vecs[i].wrdy; init_calib_complete = vecs[i].init;
            tick();
            if (vecs[i].en) begin
                check($sformatf("vec%0d_cmd", i), {p0_gnt, p1_gnt, p2_gnt, app_en, app_cmd, app_wdf_wren, app_addr},
                      {vecs[i].gnt, vecs[i].en, vecs[i].cmd, vecs[i].wren, vecs[i].addr});
                if (vecs[i].wren)
                    check($sformatf("vec%0d_wdata", i), app_wdf_data, vecs[i].gnt[1] ? P1D : P2D);
            end else begin
                check($sformatf("vec%0d_idle", i), {p0_gnt, p1_gnt, p2_gnt, app_en, app_wdf_wren},
                      {vecs[i].gnt, 2'b00});
            end
        end

        // Starvation: p0 wins every issue slot until p1 has lost 64 of them.
        idle_inputs();
        do_reset();
        init_calib_complete = 1'b1; app_wdf_rdy = 1'b1;
        p0_rd_req = 1'b1; p1_wr_req = 1'b1;
        slot = 0; outst = 0;
        for (int c = 0; c < 140; c++) begin
            logic is_slot;
            int   win;
            is_slot = (c % 2 == 0);
            win = 0;
            app_rdy = is_slot;
            app_rd_data_valid = !is_slot && (outst > 0);
            if (app_rd_data_valid) outst--;
            if (is_slot) begin
                slot++;
                win = (slot == 65) ? 1 : 0;
                if (win == 0) outst++;
            end
            tick();
            if (is_slot) begin
                check($sformatf("starve_slot%0d", slot), {p0_gnt, p1_gnt}, (win == 1) ? 2'b01 : 2'b10);
                if (win == 1) p1_wr_req = 1'b0;
            end
        end

        // Tag exhaustion: 16 reads outstanding blocks p0 but not a p1 write.
        idle_inputs();
        do_reset();
        app_rdy = 1'b1;
        p0_rd_req = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 16; c++) begin
            tick();
            if (p0_gnt) n++;
        end
        check("tag_fill_gnts", n, 16);
        p1_wr_req = 1'b1;
        tick();
        p1_wr_req = 1'b0;
        check("tag_full_p1", {p0_gnt, p1_gnt}, 2'b01);
        check("tag_full_count", dut.tag_count, 16);
        any = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            any = any | p0_gnt;
        end
        check("tag_full_blocked", any, 1'b0);
        app_rd_data_valid = 1'b1; app_rd_data = d1;
        tick();
        app_rd_data_valid = 1'b0;
        check("tag_free_valid", {p0_rd_valid, p2_rd_valid}, 2'b10);
        check("tag_free_data", p0_rd_data, d1);
        tick();
        check("tag_free_regrant", p0_gnt, 1'b1);

        // Interleaved reads return to the issuing port one cycle after each beat.
        idle_inputs();
        do_reset();
        grant_one(0, 1'b0, "ilv_p0a");
        grant_one(2, 1'b0, "ilv_p2");
        grant_one(0, 1'b0, "ilv_p0b");
        check("ilv_tags", dut.tag_count, 3);
        app_rd_data_valid = 1'b1; app_rd_data = d1;
        check("ilv_early", {p0_rd_valid, p2_rd_valid}, 2'b00);
        tick();
        check("ilv_ret1_v", {p0_rd_valid, p2_rd_valid}, 2'b10);
        check("ilv_ret1_d", p0_rd_data, d1);
        app_rd_data = d2;
        tick();
        check("ilv_ret2_v", {p0_rd_valid, p2_rd_valid}, 2'b01);
        check("ilv_ret2_d", p2_rd_data, d2);
        app_rd_data = d3;
        tick();
        app_rd_data_valid = 1'b0;
        check("ilv_ret3_v", {p0_rd_valid, p2_rd_valid}, 2'b10);
        check("ilv_ret3_d", p0_rd_data, d3);
        tick();
        check("ilv_idle", {p0_rd_valid, p2_rd_valid, rd_orphan_err}, 3'b000);

        // Orphan beat: dropped, sticky error.
        app_rd_data_valid = 1'b1; app_rd_data = 128'h77;
        tick();
        app_rd_data_valid = 1'b0;
        check("orphan_set", {p0_rd_valid, p2_rd_valid, rd_orphan_err}, 3'b001);
        tick(); tick(); tick();
        check("orphan_sticky", rd_orphan_err, 1'b1);

        // Reset with reads outstanding, then calibration low holds off grants.
        p0_rd_req = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if (p0_gnt) n++;
        end
        p0_rd_req = 1'b0;
        check("rst5_gnts", n, 5);
        check("rst5_tags", dut.tag_count, 5);
        p0_rd_req = 1'b1; p1_wr_req = 1'b1; p2_req = 1'b1; p2_we = 1'b1;
        do_reset();
        check_all_zero("rst5");
        init_calib_complete = 1'b0;
        any = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            any = any | p0_gnt | p1_gnt | p2_gnt | app_en;
        end
        check("nocal_no_grant", any, 1'b0);
        init_calib_complete = 1'b1;
        tick();
        check("cal_resume", {p0_gnt, p1_gnt, p2_gnt}, 3'b100);

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
